lsu_port_arbiter: RTL
=====================

// Module: lsu_port_arbiter
// PURPOSE
//  Shares the single 16-bit LSU between two requesters: port 0 (reservation-station data
//  accesses) and port 1 (instruction fetch). Each port gets a one-entry request buffer.
//  The arbiter selects a buffered request, issues it over the LSU start/hold handshake,
//  remembers which port owns the in-flight access, and routes the LSU write-back to it.
// PARAMETERS
//  ARB_MODE      0  0: round-robin; 1: fixed priority, port 0 first, with starvation guard
//  STARVE_LIMIT  4  (mode 1) consecutive port-0 issues while port 1 waits; then port 1 wins once
// PORTS
//  clk           in   1   clock, all state updates on posedge
//  a_rst         in   1   asynchronous reset, active low
//  pN_addr       in   16  port N (N=0,1) request address
//  pN_data       in   16  port N write data
//  pN_width      in   1   port N width: 0 = 16 bit, 1 = 8 bit
//  pN_cmd        in   1   port N command: 0 = read, 1 = write
//  pN_tag        in   2   port N request tag
//  pN_start      in   1   port N request valid
//  pN_hold       out  1   port N back-pressure; request not captured while high
//  pN_wb         out  1   read data valid for port N (one cycle)
//  wb_tag        out  2   tag of the completing read, shared by both ports
//  lsu_addr      out  16  to LSU rq_addr
//  lsu_data      out  16  to LSU rq_data
//  lsu_width     out  1   to LSU rq_width
//  lsu_cmd       out  1   to LSU rq_cmd
//  lsu_tag       out  2   to LSU rq_tag
//  lsu_start     out  1   to LSU rq_start
//  lsu_hold      in   1   from LSU rq_hold
//  lsu_wb        in   1   from LSU rs_wb
//  lsu_wb_tag    in   2   from LSU rs_tag
// BEHAVIOUR
//  Reset: all buffers invalid; pN_hold=0; lsu_start=0; pN_wb=0.
//   last_grant=1, so port 0 wins the first tie. starve_cnt=0; owner=0.
//  Capture: at a posedge with pN_start & ~pN_hold, latch addr/data/width/cmd/tag into bufN
//   and set validN.
//  Hold: pN_hold = validN & ~(issue & sel==N). A buffer may drain and refill in the same
//   cycle, so back-to-back requests from one port see no bubble.
//  Issue: lsu_start = valid0 | valid1. lsu_* fields are muxed combinationally from buf[sel].
//   Accept = lsu_start & ~lsu_hold. On accept: clear valid[sel] (unless refilled the same
//   cycle), last_grant<=sel, owner<=sel.
//   Latency: pN_start captured at edge k; lsu_start is high in cycle k+1.
//  Select, one valid: sel = that port.
//  Select, both valid, mode 0: sel = ~last_grant (strict alternation).
//  Select, both valid, mode 1: sel = 0 unless starve_cnt == STARVE_LIMIT, then sel = 1.
//  starve_cnt (mode 1, 3 bits, saturating):
//   - increments on an accepted port-0 issue while valid1 is set;
//   - clears on a port-1 issue and whenever valid1 is clear.
//  sel is recomputed every cycle. The LSU samples the lsu_* fields only on accept, so a
//   change of sel while lsu_hold is high is legal.
//  Write-back: pN_wb = lsu_wb & (owner==N); wb_tag = lsu_wb_tag.
//   - A completion and a new accept in the same cycle route the completion to the old
//     owner. owner updates at the same edge.
//   - Writes never produce lsu_wb, so owner needs no cmd qualification.
//  Boundaries:
//   - lsu_hold high with both buffers full: both holds high, buffers stable.
//   - pN_start while held is ignored; the requester must keep it asserted.
//   - Reset mid-operation discards buffered and in-flight requests; no wb is generated.
// TESTING
//  1 p0 read addr=0x1234 tag=1 -> next cycle lsu_start=1, lsu_addr=0x1234;
//    LSU completes -> p0_wb=1, wb_tag=1, p1_wb=0.
//  2 mode 0, both ports requesting continuously, lsu_hold=0 -> grant order 0,1,0,1,...;
//    each port holds every other cycle.
//  3 mode 1, STARVE_LIMIT=4, p0 continuous, p1 pending -> four p0 issues, p1 on the 5th, then p0.
//  4 both buffers full, lsu_hold=1 for 3 cycles -> p0_hold=p1_hold=1; lsu_addr, buffers unchanged.
//  5 p0 back-to-back 8-bit writes 0x0010..0x0013, lsu_hold=0 -> 4 issues in 4 consecutive
//    cycles; no p0_wb.
//  6 a_rst low while p1 read in flight and p0 buffered -> lsu_start=0 and all holds 0
//    immediately; no wb after release.

Source files
------------

// File: rtl/lsu_port_arbiter.sv
// rtl/lsu_port_arbiter.sv - two-port request arbiter in front of the single 16-bit LSU
//
// Purpose: each requester (port 0 = reservation-station data accesses, port 1 =
// instruction fetch) has a one-entry request buffer. A buffered request is selected,
// presented to the LSU over the start/hold handshake, and the owner of the accepted
// access is remembered so that its read write-back can be routed back.
//
// Ports:
//   clk, a_rst                    clock, asynchronous active-low reset
//   pN_addr/data/width/cmd/tag    port N request fields (N = 0, 1)
//   pN_start / pN_hold            port N request valid / back-pressure
//   pN_wb, wb_tag                 read completion strobe for port N, shared tag
//   lsu_addr/data/width/cmd/tag   request fields towards the LSU
//   lsu_start / lsu_hold          request valid / back-pressure towards the LSU
//   lsu_wb, lsu_wb_tag            completion strobe and tag from the LSU
module lsu_port_arbiter #(
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic [15:0] p0_addr,
  input  logic [15:0] p0_data,
  input  logic        p0_width,
  input  logic        p0_cmd,
  input  logic [1:0]  p0_tag,
  input  logic        p0_start,
  output logic        p0_hold,
  output logic        p0_wb,
  input  logic [15:0] p1_addr,
  input  logic [15:0] p1_data,
  input  logic        p1_width,
  input  logic        p1_cmd,
  input  logic [1:0]  p1_tag,
  input  logic        p1_start,
  output logic        p1_hold,
  output logic        p1_wb,
  output logic [1:0]  wb_tag,
  output logic [15:0] lsu_addr,
  output logic [15:0] lsu_data,
  output logic        lsu_width,
  output logic        lsu_cmd,
  output logic [1:0]  lsu_tag,
  output logic        lsu_start,
  input  logic        lsu_hold,
  input  logic        lsu_wb,
  input  logic [1:0]  lsu_wb_tag
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [15:0] b_addr [2];
  logic [15:0] b_data [2];
  logic        b_width [2];
  logic        b_cmd [2];
  logic [1:0]  b_tag [2];
  logic [1:0]  valid;
  logic        last_grant;
  logic        owner;
  logic [2:0]  starve_cnt;

  logic        sel;
  logic        accept;
  logic [1:0]  issue;
  logic [1:0]  cap;

  // Selection is recomputed every cycle; the LSU only samples on accept.
  always_comb begin
    sel = 1'b0;
    case (valid)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = (ARB_MODE == 0) ? ~last_grant : (starve_cnt == LIMIT);
      default: sel = 1'b0;
    endcase
  end

  assign lsu_start = valid[0] | valid[1];
  assign accept    = lsu_start & ~lsu_hold;
  assign issue[0]  = accept & ~sel;
  assign issue[1]  = accept & sel;

  // A buffer being drained this cycle can take a new request at the same edge.
  assign p0_hold = valid[0] & ~issue[0];
  assign p1_hold = valid[1] & ~issue[1];
  assign cap[0]  = p0_start & ~p0_hold;
  assign cap[1]  = p1_start & ~p1_hold;

  assign lsu_addr  = b_addr[sel];
  assign lsu_data  = b_data[sel];
  assign lsu_width = b_width[sel];
  assign lsu_cmd   = b_cmd[sel];
  assign lsu_tag   = b_tag[sel];

  // Completion goes to the owner of the previous accept, even if a new accept
  // moves ownership at this same edge. Writes never complete, so no cmd check.
  assign p0_wb  = lsu_wb & ~owner;
  assign p1_wb  = lsu_wb & owner;
  assign wb_tag = lsu_wb_tag;

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      valid      <= 2'b00;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      starve_cnt <= 3'd0;
      for (int n = 0; n < 2; n++) begin
        b_addr[n]  <= 16'h0000;
        b_data[n]  <= 16'h0000;
        b_width[n] <= 1'b0;
        b_cmd[n]   <= 1'b0;
        b_tag[n]   <= 2'b00;
      end
    end else begin
      if (cap[0]) begin
        b_addr[0]  <= p0_addr;
        b_data[0]  <= p0_data;
        b_width[0] <= p0_width;
        b_cmd[0]   <= p0_cmd;
        b_tag[0]   <= p0_tag;
      end
      if (cap[1]) begin
        b_addr[1]  <= p1_addr;
        b_data[1]  <= p1_data;
        b_width[1] <= p1_width;
        b_cmd[1]   <= p1_cmd;
        b_tag[1]   <= p1_tag;
      end
      for (int n = 0; n < 2; n++) begin
        if (cap[n])        valid[n] <= 1'b1;
        else if (issue[n]) valid[n] <= 1'b0;
      end
      if (accept) begin
        last_grant <= sel;
        owner      <= sel;
      end
      // Counts port-0 wins while port 1 is waiting; only consulted in mode 1.
      if (!valid[1] || issue[1])
        starve_cnt <= 3'd0;
      else if (issue[0] && starve_cnt != 3'd7)
        starve_cnt <= starve_cnt + 3'd1;
    end
  end

endmodule
